// File: rtl/uart_tx_arb.sv
// Frame-atomic round-robin arbiter sharing one UART transmit byte stream between PORTS AXI-stream requesters.
// Define UART_TX_ARB_TIMEOUT_EN to revoke a grant after TIMEOUT stalled cycles (pulses timeout_event).
module uart_tx_arb #(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic [PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [PORTS-1:0]            grant,
    output logic                        timeout_event
);

    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    if (PORTS < 2 || PORTS > 8 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_param_check
        $error("uart_tx_arb: PORTS or TIMEOUT out of range");
    end

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [PORTS-1:0]       grant_q, grant_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [PTR_W-1:0]       pick;
    logic                   pick_vld;
    int                     rr_idx;

    logic                   out_rdy;
    logic                   sel_vld;
    logic                   sel_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic                   accept;
    logic                   revoke;

    logic [DATA_WIDTH-1:0]  data_p0;
    logic                   last_p0;
    logic                   vld_p0;

    // Round-robin pick: scan from ptr_q upward, lowest offset wins.
    always_comb begin
        pick     = ptr_q;
        pick_vld = 1'b0;
        rr_idx   = 0;
        for (int k = PORTS - 1; k >= 0; k--) begin
            rr_idx = (int'(ptr_q) + k) % PORTS;
            if (s_axis_tvalid[rr_idx]) begin
                pick     = PTR_W'(rr_idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign sel_vld  = s_axis_tvalid[owner_q];
    assign sel_last = s_axis_tlast[owner_q];
    assign sel_data = s_axis_tdata[owner_q*DATA_WIDTH +: DATA_WIDTH];

    // The output stage can take a beat when empty or draining this cycle.
    assign out_rdy       = ~vld_p0 | m_axis_tready;
    assign s_axis_tready = (state_q == GRANTED && out_rdy) ? grant_q : '0;
    assign accept        = (state_q == GRANTED) && sel_vld && out_rdy;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0] stall_q;
    logic        tmo_hit;
    logic        tev_q;

    // Fires on the stall cycle that brings the counter up to TIMEOUT.
    assign tmo_hit = (state_q == GRANTED) && !sel_vld && (stall_q == 16'(TIMEOUT - 1));
    assign revoke  = (accept && sel_last) || tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            tev_q   <= 1'b0;
        end else begin
            tev_q <= tmo_hit;
            if (state_q != GRANTED || accept || tmo_hit) begin
                stall_q <= '0;
            end else if (!sel_vld) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign timeout_event = tev_q;
`else
    assign revoke        = accept && sel_last;
    assign timeout_event = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d       = GRANTED;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    owner_d       = pick;
                end
            end
            GRANTED: begin
                if (revoke) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = (owner_q == PTR_W'(PORTS - 1)) ? '0 : owner_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Stage p0: single registered output beat toward the UART.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
            last_p0 <= 1'b0;
        end else if (accept) begin
            vld_p0  <= 1'b1;
            data_p0 <= sel_data;
            last_p0 <= sel_last;
        end else if (m_axis_tready) begin
            vld_p0 <= 1'b0;
        end
    end

    assign m_axis_tvalid = vld_p0;
    assign m_axis_tdata  = data_p0;
    assign m_axis_tlast  = last_p0;
    assign grant         = grant_q;

endmodule
